bcd_serial_alu: RTL and testbench

- Parametrised, multi-digit, digit-serial BCD add/subtract unit. It is the sequential successor to the team's single-digit combinational BCD adder.
- Operands are DIGITS packed BCD digits. The unit processes one digit per clock, least-significant digit first.
- Subtraction uses a ten's-complement correction pass, so the result is reported as sign plus magnitude.
- Result digits are decoded to active-low 7-segment patterns for the board HEX displays. A start/busy/done handshake sits between the switch front end and the display.

---
 rtl/bcd_serial_alu.sv | 208 ++++++++++++++++++++
 tb/tb_bcd_serial_alu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_alu.sv
// Digit-serial BCD add/subtract unit, one digit per clock, LSD first.
// Subtraction is nine's-complement add with carry-in 1; a negative result
// gets a second serial pass that ten's-complements it into a magnitude.
// The held result drives active-low 7-segment patterns for the HEX displays.
module bcd_serial_alu #(
  parameter int DIGITS        = 4,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   a_in,
  input  logic [4*DIGITS-1:0]   b_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  neg,
  output logic                  ovf,
  output logic                  err,
  output logic [7*DIGITS-1:0]   HEX_DIGITS,
  output logic [6:0]            HEX_SIGN
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  localparam logic [6:0] BLANK = 7'b111_1111;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_FIX, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b, r_res;
  logic            r_op, r_c;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_result;
  logic            r_neg, r_ovf, r_err, r_valid;

  logic            w_accept, w_bad, w_last;
  logic [3:0]      w_ak, w_bk, w_dig;
  logic [4:0]      w_sum;
  logic            w_cout;
  logic [W-1:0]    w_res_nxt;
  logic [DIGITS-1:0] w_lit;
  logic            w_seen;

  // Active-low a..g segment pattern for one BCD digit.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b000_0001;
      4'd1:    f_seg = 7'b100_1111;
      4'd2:    f_seg = 7'b001_0010;
      4'd3:    f_seg = 7'b000_0110;
      4'd4:    f_seg = 7'b100_1100;
      4'd5:    f_seg = 7'b010_0100;
      4'd6:    f_seg = 7'b010_0000;
      4'd7:    f_seg = 7'b000_1111;
      4'd8:    f_seg = 7'b000_0000;
      4'd9:    f_seg = 7'b000_1100;
      default: f_seg = BLANK;
    endcase
  endfunction

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_cnt == LAST);

  // Flag any non-BCD nibble on either operand at accept time.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_in[4*i +: 4] > 4'd9 || b_in[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  // One-digit BCD adder; in FIX it complements the partial result digit instead.
  always_comb begin
    if (r_state == S_FIX) begin
      w_ak = 4'd9 - r_res[3:0];
      w_bk = 4'd0;
    end else begin
      w_ak = r_a[3:0];
      w_bk = r_op ? (4'd9 - r_b[3:0]) : r_b[3:0];
    end
    w_sum = {1'b0, w_ak} + {1'b0, w_bk} + {4'b0, r_c};
    if (w_sum > 5'd9) begin
      w_dig  = 4'(w_sum - 5'd10);
      w_cout = 1'b1;
    end else begin
      w_dig  = w_sum[3:0];
      w_cout = 1'b0;
    end
  end

  // New digit enters at the MSB so digit 0 lands at [3:0] after DIGITS shifts.
  generate
    if (DIGITS == 1) begin : g_one
      assign w_res_nxt = w_dig;
    end else begin : g_many
      assign w_res_nxt = {w_dig, r_res[W-1:4]};
    end
  endgenerate

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_bad ? S_DONE : S_ADD;
      S_ADD:  if (w_last)   w_next = (!r_op || w_cout) ? S_DONE : S_FIX;
      S_FIX:  if (w_last)   w_next = S_DONE;
      S_DONE: w_next = w_accept ? (w_bad ? S_DONE : S_ADD) : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand shifters, carry, digit counter and the held result/flags.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_a <= '0; r_b <= '0; r_res <= '0;
      r_op <= 1'b0; r_c <= 1'b0; r_cnt <= '0;
      r_result <= '0; r_neg <= 1'b0; r_ovf <= 1'b0; r_err <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_op  <= op;
            r_c   <= op;
            r_cnt <= '0;
            if (w_bad) begin
              r_result <= '0;
              r_err    <= 1'b1;
              r_neg    <= 1'b0;
              r_ovf    <= 1'b0;
              r_valid  <= 1'b1;
            end
          end
        end
        S_ADD: begin
          r_a   <= r_a >> 4;
          r_b   <= r_b >> 4;
          r_res <= w_res_nxt;
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt <= '0;
            if (!r_op || w_cout) begin
              // Add (possibly wrapping) or non-negative subtract: done now.
              r_result <= w_res_nxt;
              r_ovf    <= !r_op && w_cout;
              r_neg    <= 1'b0;
              r_err    <= 1'b0;
              r_valid  <= 1'b1;
            end else begin
              // Borrow out: seed the complement pass with carry-in 1.
              r_c <= 1'b1;
            end
          end
        end
        S_FIX: begin
          r_res <= w_res_nxt;
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt    <= '0;
            r_result <= w_res_nxt;
            r_neg    <= 1'b1;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == S_ADD) || (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign neg    = r_neg;
  assign ovf    = r_ovf;
  assign err    = r_err;

  // Segment decode from the held result, with optional leading-zero blanking.
  always_comb begin
    w_seen     = 1'b0;
    w_lit      = '0;
    HEX_DIGITS = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (r_result[4*k +: 4] != 4'd0) w_seen = 1'b1;
      w_lit[k] = !BLANK_LEADING || w_seen || (k == 0);
      if (r_valid && !r_err && w_lit[k])
        HEX_DIGITS[7*k +: 7] = f_seg(r_result[4*k +: 4]);
      else
        HEX_DIGITS[7*k +: 7] = BLANK;
    end
    HEX_SIGN = (r_valid && r_neg) ? 7'b111_1110 : BLANK;
  end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Scoreboard bench for bcd_serial_alu (DIGITS=4): expected results are
// pushed when a start is issued and popped when done is observed.
module tb_bcd_serial_alu;

  localparam int D = 4;
  localparam logic [6:0] BL = 7'b111_1111;
  localparam logic [6:0] SEG [0:9] = '{7'b000_0001, 7'b100_1111, 7'b001_0010,
    7'b000_0110, 7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
    7'b000_0000, 7'b000_1100};

  typedef struct {
    logic [4*D-1:0] res;
    logic neg, ovf, err;
    int   lat;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  logic start = 1'b0, op = 1'b0;
  logic [4*D-1:0] a_in = '0, b_in = '0;
  logic busy, done, neg, ovf, err;
  logic [4*D-1:0] result;
  logic [7*D-1:0] HEX_DIGITS;
  logic [6:0] HEX_SIGN;
  logic busy2, done2, neg2, ovf2, err2;
  logic [4*D-1:0] result2;
  logic [7*D-1:0] hex2;
  logic [6:0] sign2;

  exp_t sb[$];
  int ncmp = 0, nfail = 0;

  bcd_serial_alu #(.DIGITS(D), .BLANK_LEADING(1'b0)) u_dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result(result),
    .neg(neg), .ovf(ovf), .err(err), .HEX_DIGITS(HEX_DIGITS), .HEX_SIGN(HEX_SIGN));

  bcd_serial_alu #(.DIGITS(D), .BLANK_LEADING(1'b1)) u_dut_bl (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy2), .done(done2), .result(result2),
    .neg(neg2), .ovf(ovf2), .err(err2), .HEX_DIGITS(hex2), .HEX_SIGN(sign2));

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic int bcd2int(input logic [4*D-1:0] v);
    int r = 0;
    for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [4*D-1:0] int2bcd(input int v);
    logic [4*D-1:0] r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                                 input logic o);
    exp_t e;
    int ai, bi, p10;
    e.res = '0; e.neg = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.lat = D + 1;
    for (int k = 0; k < D; k++)
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) e.err = 1'b1;
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    ai = bcd2int(a); bi = bcd2int(b); p10 = 10 ** D;
    if (!o) begin
      e.ovf = (ai + bi) >= p10;
      e.res = int2bcd((ai + bi) % p10);
    end else if (ai >= bi) begin
      e.res = int2bcd(ai - bi);
    end else begin
      e.res = int2bcd(bi - ai);
      e.neg = 1'b1;
      e.lat = 2 * D + 1;
    end
    return e;
  endfunction

  function automatic logic [7*D-1:0] exp_hex(input exp_t e);
    logic [7*D-1:0] h = '1;
    if (!e.err)
      for (int k = 0; k < D; k++) h[7*k +: 7] = SEG[e.res[4*k +: 4]];
    return h;
  endfunction

  // Called just after a negedge: drive a request and let one rising edge accept it.
  task automatic issue(input logic [4*D-1:0] a, input logic [4*D-1:0] b, input logic o);
    sb.push_back(model(a, b, o));
    a_in = a; b_in = b; op = o; start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done; cnt0 = edges since accept at the next negedge.
  task automatic wait_done(input string tag, input int cnt0);
    exp_t e;
    int cnt = cnt0;
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (done) begin
        got = 1'b1;
        break;
      end
      cnt++;
    end
    ncmp++;
    if (!got) begin
      nfail++;
      $display("FAIL %s timeout: done never seen, required within 40 cycles", tag);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      nfail++;
      $display("FAIL %s: done seen with empty scoreboard", tag);
      return;
    end
    e = sb.pop_front();
    ncmp++; if (cnt !== e.lat) begin nfail++; $display("FAIL %s latency: got %0d exp %0d", tag, cnt, e.lat); end
    ncmp++; if (result !== e.res) begin nfail++; $display("FAIL %s result: got %h exp %h", tag, result, e.res); end
    ncmp++; if (neg !== e.neg) begin nfail++; $display("FAIL %s neg: got %b exp %b", tag, neg, e.neg); end
    ncmp++; if (ovf !== e.ovf) begin nfail++; $display("FAIL %s ovf: got %b exp %b", tag, ovf, e.ovf); end
    ncmp++; if (err !== e.err) begin nfail++; $display("FAIL %s err: got %b exp %b", tag, err, e.err); end
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL %s busy at done: got %b exp 0", tag, busy); end
    ncmp++; if (HEX_DIGITS !== exp_hex(e)) begin nfail++; $display("FAIL %s hex: got %h exp %h", tag, HEX_DIGITS, exp_hex(e)); end
    ncmp++; if (HEX_SIGN !== (e.neg ? 7'b111_1110 : BL)) begin nfail++; $display("FAIL %s sign: got %b exp %b", tag, HEX_SIGN, (e.neg ? 7'b111_1110 : BL)); end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    ncmp++; if ({busy, done, neg, ovf, err} !== 5'b0) begin nfail++; $display("FAIL reset flags: got %b exp 00000", {busy, done, neg, ovf, err}); end
    ncmp++; if (result !== '0) begin nfail++; $display("FAIL reset result: got %h exp 0000", result); end
    ncmp++; if (HEX_DIGITS !== '1 || HEX_SIGN !== BL) begin nfail++; $display("FAIL reset hex: got %h/%b exp all ones", HEX_DIGITS, HEX_SIGN); end
    ncmp++; if (hex2 !== '1) begin nfail++; $display("FAIL reset hex_bl: got %h exp all ones", hex2); end
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic test_add();
    issue(16'h1234, 16'h5678, 1'b0); wait_done("add_1234_5678", 1);
    ncmp++; if (HEX_DIGITS[6:0] !== 7'b001_0010) begin nfail++; $display("FAIL add digit0 seg: got %b exp 0010010", HEX_DIGITS[6:0]); end
    @(negedge CLOCK_50);
    ncmp++; if (done !== 1'b0 || result !== 16'h6912) begin nfail++; $display("FAIL add hold: got done=%b res=%h exp done=0 res=6912", done, result); end
    issue(16'h9999, 16'h0001, 1'b0); wait_done("add_wrap", 1);
    issue(16'h0000, 16'h0000, 1'b0); wait_done("add_zero", 1);
  endtask

  task automatic test_sub();
    issue(16'h5000, 16'h1234, 1'b1); wait_done("sub_pos", 1);
    issue(16'h0345, 16'h0345, 1'b1); wait_done("sub_equal", 1);
    issue(16'h0012, 16'h0345, 1'b1); wait_done("sub_neg", 1);
    ncmp++; if (hex2 !== {BL, SEG[3], SEG[3], SEG[3]}) begin nfail++; $display("FAIL blank_leading hex: got %h exp %h", hex2, {BL, SEG[3], SEG[3], SEG[3]}); end
    ncmp++; if (sign2 !== 7'b111_1110) begin nfail++; $display("FAIL blank_leading sign: got %b exp 1111110", sign2); end
  endtask

  task automatic test_err();
    issue(16'h12A4, 16'h0000, 1'b0); wait_done("err_a", 1);
    issue(16'h0001, 16'hF000, 1'b1); wait_done("err_b", 1);
  endtask

  task automatic test_busy_ignore();
    int extra = 0;
    sb.push_back(model(16'h2222, 16'h3333, 1'b0));
    a_in = 16'h2222; b_in = 16'h3333; op = 1'b0; start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    @(negedge CLOCK_50);
    a_in = 16'h9999; b_in = 16'h9999; op = 1'b1; start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    wait_done("busy_ignore", 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      if (done) extra++;
    end
    ncmp++; if (extra !== 0) begin nfail++; $display("FAIL busy_ignore extra done: got %0d exp 0", extra); end
    ncmp++; if (result !== 16'h5555) begin nfail++; $display("FAIL busy_ignore held: got %h exp 5555", result); end
  endtask

  task automatic test_back_to_back();
    issue(16'h0001, 16'h0002, 1'b0); wait_done("b2b_1", 1);
    issue(16'h0500, 16'h0900, 1'b1); wait_done("b2b_2", 1);
    issue(16'h00A0, 16'h0000, 1'b0); wait_done("b2b_err", 1);
    issue(16'h0100, 16'h0050, 1'b1); wait_done("b2b_3", 1);
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    issue(16'h0012, 16'h0345, 1'b1);
    for (int i = 0; i < 6; i++) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #1;
    ncmp++; if (busy !== 1'b0 || done !== 1'b0) begin nfail++; $display("FAIL reset_mid busy/done: got %b%b exp 00", busy, done); end
    ncmp++; if (result !== '0 || neg !== 1'b0) begin nfail++; $display("FAIL reset_mid result: got %h neg=%b exp 0000 neg=0", result, neg); end
    ncmp++; if (HEX_DIGITS !== '1 || HEX_SIGN !== BL) begin nfail++; $display("FAIL reset_mid hex: got %h/%b exp all ones", HEX_DIGITS, HEX_SIGN); end
    sb.delete();
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLOCK_50);
      if (done) extra++;
    end
    ncmp++; if (extra !== 0) begin nfail++; $display("FAIL reset_mid done after abort: got %0d exp 0", extra); end
    issue(16'h1234, 16'h0001, 1'b0); wait_done("after_reset", 1);
  endtask

  task automatic test_random();
    logic [4*D-1:0] a, b;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < D; k++) begin
        a[4*k +: 4] = 4'($urandom_range(9));
        b[4*k +: 4] = 4'($urandom_range(9));
      end
      issue(a, b, 1'($urandom_range(1))); wait_done("random", 1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_err();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
